axis_sample_player: RTL
=======================

# axis_sample_player

- AXI-Stream master that replays a frame of signed 16-bit samples from an internal sample memory.
- Feeds the FIR filter's slave stream input (`s_axis_fir_*`): tdata 16 bit, tkeep 4 bit, tlast, tvalid/tready.
- Host or testbench loads the memory through a simple write port, then pulses `start`.
- Full AXI-Stream backpressure compliance at one beat per cycle sustained.

## Interface
- `DEPTH`, default 64: sample memory entries, power of two.
- `ADDR_W`, default 6: log2(DEPTH).
- `clk` in, 1: clock; all logic on rising edge.
- `reset` in, 1: asynchronous, active-low.
- `wr_en` in, 1: sample memory write strobe.
- `wr_addr` in, ADDR_W: write address.
- `wr_data` in, 16: signed sample to write.
- `frame_len` in, ADDR_W+1: beats per frame, 1..DEPTH; sampled on accepted `start`.
- `start` in, 1: single-cycle start pulse.
- `loop` in, 1: replay frames continuously (see Configuration).
- `busy` out, 1: high from accepted `start` until the final frame completes.
- `done` out, 1: one-cycle pulse after each frame's last handshake.
- `m_axis_tdata` out, 16 signed: sample.
- `m_axis_tkeep` out, 4: constant 4'hF whenever tvalid is high.
- `m_axis_tlast` out, 1: high on beat index frame_len-1.
- `m_axis_tvalid` out, 1: beat valid.
- `m_axis_tready` in, 1: downstream ready.

## Operation
- **Reset values:** all outputs 0, including tkeep. FSM returns to IDLE. Memory contents are not cleared.
- **Memory:** synchronous write, synchronous read with 1-cycle latency. Same-address write and read in one cycle returns old data.
- **FSM states:**
  - IDLE: `busy`=0, tvalid=0.
  - PRIME: issue the read for addr 0.
  - STREAM: present beats.
  - LAST: final beat waiting for handshake.
- **Transitions:**
  - IDLE→PRIME on `start` with frame_len≠0. Latch frame_len; beat counter = 0.
  - `start` with frame_len=0, or while busy: ignored.
  - frame_len > DEPTH is clamped to DEPTH.
  - PRIME→STREAM after one cycle.
  - STREAM→LAST when the beat at index frame_len-1 is presented.
  - LAST→IDLE on handshake when loop is clear.
  - LAST→STREAM on handshake when loop is set: counter wraps to 0 and addr 0 is re-read with no bubble.
- **Handshake rules:**
  - A beat transfers when tvalid && tready.
  - Once tvalid is high, tdata, tlast and tkeep hold stable and tvalid stays high until the handshake.
  - tvalid never depends combinationally on tready.
- **Prefetch:** a 2-entry skid/output register gives one beat per cycle while tready=1, with no lost or duplicated samples when tready toggles.
- **Addressing:** beat n carries mem[n]. The counter is ADDR_W+1 bits and is compared against latched frame_len-1.
- **Writes during STREAM** are allowed. Data written to an address not yet read appears in the frame; otherwise it takes effect in the next frame.
- **Reset mid-frame:** outputs drop immediately and asynchronously; no partial beat is completed after reset release.

## Timing
- **Start latency:** `start` at cycle 0 gives `busy`=1 at cycle 1 and first tvalid=1 at cycle 2 with tdata=mem[0].
- **Throughput:** with tready held high, frame beats occupy consecutive cycles; frame_len N takes N cycles.
- **`done`:** asserted the cycle after the last handshake, for exactly 1 cycle.
- **`busy` (no loop):** falls in the same cycle `done` rises.
- **Looping:** the first beat of the next frame is valid the cycle after the prior tlast handshake.
- **Loop release:** loop deasserted during a frame ends playback after that frame's tlast. loop is sampled at the tlast handshake.

## Configuration
- **Macro `SAMPLE_PLAYER_LOOP_EN`.**
- **Defined:** the `loop` input is honoured as described above.
- **Undefined:**
  - `loop` is ignored (treated as 0); every start plays exactly one frame.
  - The LAST→STREAM transition is not synthesized.
  - The port remains present so instantiation is unchanged.

## Test plan
- **Reset:** hold reset=0 for 3 cycles mid-stream → all outputs 0 immediately; after release, tvalid stays 0 until the next `start`.
- **Single frame:**
  - Stimulus: load mem[0..7]=16'h0001..16'h0008, frame_len=8, tready=1, start.
  - Required: tvalid at cycles 2..9 with data 1..8; tlast only at cycle 9; tkeep=4'hF; `done` at cycle 10; `busy` falls at cycle 10.
- **Backpressure:** same frame, tready pattern 1,0,0,1,0,1… → each sample transfers exactly once and in order; tdata and tlast are stable while tvalid=1 and tready=0.
- **Boundaries:**
  - frame_len=1 → single beat 16'h0001 with tlast=1.
  - frame_len=0 → start ignored, busy stays 0.
  - frame_len=64 → tlast on mem[63].
- **Loop (macro defined):**
  - Stimulus: frame_len=4, loop=1, tready=1.
  - Required: continuous 1,2,3,4,1,2,3,4 with tlast every 4th beat and `done` after each frame.
  - Drop loop mid-second frame → stops after that frame's tlast.
- **Write during stream:** frame_len=16; write mem[12]=16'h7FFF while beat 3 transfers → beat 12 carries 16'h7FFF.

Source files
------------

// File: rtl/axis_sample_player.sv
// axis_sample_player: AXI-Stream master that replays a frame of signed 16-bit
// samples from an internal sample memory into the FIR slave stream input.
// The host loads the memory through a simple write port and pulses start.
// A two-entry output/skid register pair sustains one beat per cycle under
// arbitrary backpressure without losing or duplicating samples.
//
// Build option: define SAMPLE_PLAYER_LOOP_EN to honour the loop input
// (continuous frame replay). Without it, loop is ignored and each start
// plays exactly one frame; the port is kept so instantiation is unchanged.

module axis_sample_player #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [15:0]       wr_data,
    input  logic [ADDR_W:0]          frame_len,
    input  logic                     start,
    input  logic                     loop,
    output logic                     busy,
    output logic                     done,
    output logic signed [15:0]       m_axis_tdata,
    output logic [3:0]               m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_STREAM = 2'd2,
        S_LAST   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    // Sample memory (never reset)
    logic signed [15:0] r_mem [DEPTH];

    // Control state
    state_t             r_state;
    logic [ADDR_W:0]    r_len;      // latched, clamped frame length
    logic [ADDR_W:0]    r_idx;      // index of the next sample to fetch
    logic               r_busy;
    logic               r_done;

    // Output register (head) and skid register
    logic signed [15:0] r_out_data;
    logic               r_out_last;
    logic               r_out_vld;
    logic signed [15:0] r_skid_data;
    logic               r_skid_last;
    logic               r_skid_vld;

    // Combinational helpers
    logic               w_loop;
    logic               w_pop;
    logic               w_wrap;
    logic               w_fetch;
    logic [ADDR_W-1:0]  w_fetch_addr;
    logic signed [15:0] w_fetch_data;
    logic               w_fetch_last;
    logic [ADDR_W:0]    w_idx_nxt;
    logic [ADDR_W:0]    w_len_clamped;

    logic signed [15:0] w_out_data_n;
    logic               w_out_last_n;
    logic               w_out_vld_n;
    logic signed [15:0] w_skid_data_n;
    logic               w_skid_last_n;
    logic               w_skid_vld_n;

`ifdef SAMPLE_PLAYER_LOOP_EN
    assign w_loop = loop;
`else
    logic w_unused_loop;
    assign w_unused_loop = loop;
    assign w_loop        = 1'b0;
`endif

    // A beat leaves the head register on a valid/ready handshake.
    assign w_pop  = r_out_vld & m_axis_tready;

    // Handshake of the final beat with loop set restarts at address 0 in
    // the same edge, so the next frame follows with no bubble.
    assign w_wrap = (r_state == S_LAST) & w_pop & w_loop;

    // Fetch while samples remain and a slot is (or becomes) free. Reads stay
    // at most two beats ahead of the consumer, so late writes to addresses
    // not yet fetched still land in the current frame.
    assign w_fetch = w_wrap |
                     ((r_state != S_IDLE) && (r_idx != r_len) &&
                      (!r_skid_vld || w_pop));

    assign w_fetch_addr  = w_wrap ? '0 : r_idx[ADDR_W-1:0];
    assign w_fetch_data  = r_mem[w_fetch_addr];
    assign w_fetch_last  = w_wrap ? (r_len == LEN_ONE) : (r_idx == (r_len - LEN_ONE));
    assign w_idx_nxt     = w_wrap ? LEN_ONE : (r_idx + LEN_ONE);
    assign w_len_clamped = (frame_len > LEN_MAX) ? LEN_MAX : frame_len;

    // Sample memory write port; a read in the same cycle sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Next contents of the head/skid pair given pop and fetch.
    always_comb begin
        w_out_data_n  = r_out_data;
        w_out_last_n  = r_out_last;
        w_out_vld_n   = r_out_vld;
        w_skid_data_n = r_skid_data;
        w_skid_last_n = r_skid_last;
        w_skid_vld_n  = r_skid_vld;
        if (!r_out_vld || w_pop) begin
            if (r_skid_vld) begin
                // Skid drains into the head; a concurrent fetch refills skid.
                w_out_data_n  = r_skid_data;
                w_out_last_n  = r_skid_last;
                w_out_vld_n   = 1'b1;
                w_skid_vld_n  = w_fetch;
                w_skid_data_n = w_fetch ? w_fetch_data : r_skid_data;
                w_skid_last_n = w_fetch & w_fetch_last;
            end else if (w_fetch) begin
                w_out_data_n  = w_fetch_data;
                w_out_last_n  = w_fetch_last;
                w_out_vld_n   = 1'b1;
            end else begin
                w_out_data_n  = '0;
                w_out_last_n  = 1'b0;
                w_out_vld_n   = 1'b0;
            end
        end else if (w_fetch) begin
            // Head is stalled; park the fetched sample in the skid slot.
            w_skid_data_n = w_fetch_data;
            w_skid_last_n = w_fetch_last;
            w_skid_vld_n  = 1'b1;
        end
    end

    // Player FSM with registered outputs and the head/skid registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_vld   <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
            r_skid_vld  <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_out_data  <= w_out_data_n;
            r_out_last  <= w_out_last_n;
            r_out_vld   <= w_out_vld_n;
            r_skid_data <= w_skid_data_n;
            r_skid_last <= w_skid_last_n;
            r_skid_vld  <= w_skid_vld_n;
            if (w_fetch) begin
                r_idx <= w_idx_nxt;
            end
            case (r_state)
                S_IDLE: begin
                    // A zero-length start is ignored; busy filters restarts.
                    if (start && (frame_len != '0)) begin
                        r_len   <= w_len_clamped;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_PRIME;
                    end
                end
                S_PRIME, S_STREAM: begin
                    r_state <= (w_out_vld_n && w_out_last_n) ? S_LAST : S_STREAM;
                end
                S_LAST: begin
                    if (w_pop) begin
                        r_done <= 1'b1;
                        if (w_loop) begin
                            r_state <= w_out_last_n ? S_LAST : S_STREAM;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tvalid = r_out_vld;
    assign m_axis_tkeep  = r_out_vld ? 4'hF : 4'h0;

endmodule
